// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, sign-fixed in FIN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 signed_op;
  logic [WIDTH:0]       mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    signed_op = ~op[0];

    // Multiply: a_q is the multiplicand, b_q shifts right as the multiplier.
    // Divide: a_q shifts the dividend out MSB-first, b_q is the divisor.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_q};
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot_fix = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          sa_d     = signed_op & srcA[WIDTH-1];
          sb_d     = signed_op & srcB[WIDTH-1];
          a_d      = (signed_op & srcA[WIDTH-1]) ? -srcA : srcA;
          b_d      = (signed_op & srcB[WIDTH-1]) ? -srcB : srcB;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          if (hiWrite) hi_d = writeData;
          if (loWrite) lo_d = writeData;
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~diff[WIDTH]};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: random and directed operations scored against an
// arithmetic reference model through an expected-result queue.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        hiWrite, loWrite;
  logic [31:0] writeData;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hi_arch, lo_arch;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic, returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa_v, sb_v;
    logic [31:0] q, rm;
    logic [63:0] r;
    sa_v = longint'($signed(a));
    sb_v = longint'($signed(b));
    case (o)
      2'd0: r = 64'(sa_v * sb_v);
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          q  = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          rm = a;
        end else begin
          q  = 32'(sa_v / sb_v);
          rm = 32'(sa_v % sb_v);
        end
        r = {rm, q};
      end
      default: begin
        if (b == 32'd0) begin
          q  = 32'hFFFF_FFFF;
          rm = a;
        end else begin
          q  = a / b;
          rm = a % b;
        end
        r = {rm, q};
      end
    endcase
    return r;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result %h want no done", {hi, lo});
      end else begin
        check("result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // mode 0: plain, 1: start pulse + srcA noise while busy,
  // 2: hiWrite while busy, 3: hiWrite together with start
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int mode);
    int          bc;
    logic [63:0] e;
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    if (mode == 3) begin
      hiWrite   = 1'b1;
      writeData = ~hi_arch;
    end
    e = model(o, a, b);
    exp_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    hiWrite = 1'b0;
    srcA    = $urandom;
    srcB    = $urandom;
    op      = 2'($urandom_range(0, 3));
    if (mode == 3) check("hiwrite_with_start", {32'd0, hi}, {32'd0, hi_arch});
    bc = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (busy) bc++;
      if (mode == 1) begin
        srcA  = $urandom;
        start = (i == 9);
      end
      if (mode == 2 && i == 5) begin
        hiWrite   = 1'b1;
        writeData = ~hi_arch;
      end
      if (mode == 2 && i == 6) begin
        hiWrite = 1'b0;
        check("hiwrite_busy", {32'd0, hi}, {32'd0, hi_arch});
      end
      @(negedge clk);
    end
    start   = 1'b0;
    hiWrite = 1'b0;
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_len", 64'(bc), 64'd33);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    hi_arch = e[63:32];
    lo_arch = e[31:0];
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int extra;
    reset = 1'b1; start = 1'b0; op = 2'd0; srcA = '0; srcB = '0;
    hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
    hi_arch = '0; lo_arch = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", {62'd0, dbg_state}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed arithmetic, back-to-back
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'd3, 32'h1234_5678, 32'd0, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 0);

    // ignored start and operand changes while busy
    do_op(2'd1, 32'd5, 32'd6, 1);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("extra_done", 64'(extra), 64'd0);

    // MTHI / MTLO in idle
    hiWrite = 1'b1; writeData = 32'hA5A5_A5A5;
    @(negedge clk);
    hiWrite = 1'b0;
    check("mthi_value", {32'd0, hi}, 64'h0000_0000_A5A5_A5A5);
    check("mthi_no_done", {63'd0, done}, 64'd0);
    hi_arch = 32'hA5A5_A5A5;
    loWrite = 1'b1; writeData = 32'h5A5A_1234;
    @(negedge clk);
    loWrite = 1'b0;
    check("mtlo_value", {32'd0, lo}, 64'h0000_0000_5A5A_1234);
    check("mtlo_hi_kept", {32'd0, hi}, {32'd0, hi_arch});
    lo_arch = 32'h5A5A_1234;

    do_op(2'd1, 32'd9, 32'd11, 2);
    do_op(2'd3, 32'd100, 32'd7, 3);

    // reset in the middle of a divide
    start = 1'b1; op = 2'd3; srcA = 32'hDEAD_BEEF; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_state", {62'd0, dbg_state}, 64'd0);
    hi_arch = '0; lo_arch = '0;
    repeat (40) @(negedge clk);
    do_op(2'd1, 32'd3, 32'd4, 0);

    // randomized operations
    for (int k = 0; k < 24; k++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick(), 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
